// File: rtl/sbc_dma_arbiter.sv
// sbc_dma_arbiter: shares the 13-bit memory bus between the 6507 core and a block-copy DMA engine.
// The CPU is stalled via cpu_rdy while bytes are copied, then its frozen cycle is re-presented.
module sbc_dma_arbiter #(
    parameter logic [12:0] CFG_BASE = 13'h0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_wenb,
    output logic [7:0]  cpu_d_in,
    output logic        cpu_rdy,
    input  logic        ext_rdy,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_wenb,
    input  logic [7:0]  mem_d_in,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESTORE} state_t;
    state_t      state;
    logic [7:0]  src_lo, dst_lo, len, data;
    logic [4:0]  src_hi, dst_hi;
    logic [12:0] src, dst;
    logic [8:0]  cnt;
    logic        win, reg_wr, pass;
    assign win      = cpu_addr[12:3] == CFG_BASE[12:3];
    assign reg_wr   = win && !cpu_wenb && state == IDLE;
    assign cpu_d_in = mem_d_in;
    assign cpu_rdy  = ext_rdy && state == IDLE;
    assign busy     = state != IDLE;
    // RESTORE re-presents the CPU's frozen cycle so mem_d_in is valid when rdy returns
    always_comb begin
        pass      = state == IDLE || state == RESTORE;
        mem_addr  = pass ? cpu_addr : (state == WR ? dst : src);
        mem_d_out = pass ? cpu_d_out : data;
        mem_wenb  = pass ? (cpu_wenb | win) : (state != WR);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            src_lo <= '0;
            src_hi <= '0;
            dst_lo <= '0;
            dst_hi <= '0;
            len    <= '0;
            data   <= '0;
            src    <= '0;
            dst    <= '0;
            cnt    <= '0;
        end else begin
            done <= ext_rdy && state == RESTORE;
            if (ext_rdy) begin
                case (state)
                    IDLE: if (reg_wr) begin
                        case (cpu_addr[2:0])
                            3'd0: src_lo <= cpu_d_out;
                            3'd1: src_hi <= cpu_d_out[4:0];
                            3'd2: dst_lo <= cpu_d_out;
                            3'd3: dst_hi <= cpu_d_out[4:0];
                            3'd4: len    <= cpu_d_out;
                            3'd5: if (cpu_d_out[0]) begin
                                cnt   <= {len == 8'd0, len};
                                src   <= {src_hi, src_lo};
                                dst   <= {dst_hi, dst_lo};
                                state <= RD;
                            end
                            default: ;
                        endcase
                    end
                    RD: state <= CAP;
                    CAP: begin
                        data  <= mem_d_in;
                        state <= WR;
                    end
                    WR: begin
                        src   <= src + 13'd1;
                        dst   <= dst + 13'd1;
                        cnt   <= cnt - 9'd1;
                        state <= cnt == 9'd1 ? RESTORE : RD;
                    end
                    RESTORE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/sbc_dma_arbiter.md
Name: sbc_dma_arbiter

Overview:
Shares the SBC's single 13-bit memory bus between the 6507 core and a block-copy DMA engine. The CPU programs the engine through a write-only register window. A CTRL write stalls the CPU via its rdy input, the engine copies N bytes, and the CPU's frozen bus cycle is restored before rdy is released. The block sits between the CPU core and the RAM/ROM/IO decode.

Parameters:
CFG_BASE, 13'h0200, base of the 8-byte register window; must be 8-aligned.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_addr  in  13  CPU address bus
cpu_d_out  in  8  CPU write data
cpu_wenb  in  1  CPU write enable, active-low
cpu_d_in  out  8  read data to CPU; always equals mem_d_in
cpu_rdy  out  1  CPU advance enable
ext_rdy  in  1  external wait request; 0 stalls both CPU and DMA
mem_addr  out  13  address to memory decode
mem_d_out  out  8  write data to memory
mem_wenb  out  1  memory write enable, active-low
mem_d_in  in  8  memory read data; synchronous, valid in the cycle after the address is presented
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse on transfer completion

Behaviour:
- Register window: CFG_BASE+0 SRC_LO, +1 SRC_HI (bits 4:0 used), +2 DST_LO, +3 DST_HI (bits 4:0 used), +4 LEN (8-bit; 0 means 256), +5 CTRL (bit0 = start), +6/+7 ignored.
- A register write occurs in the cycle where cpu_wenb=0 and cpu_addr lies in the window. It is captured at the clock edge.
- Window writes are not forwarded: mem_wenb=1 in that cycle. Window reads pass through to memory unchanged.
- Reset: all registers 0, state IDLE, busy=0, done=0, cpu_rdy=ext_rdy.
- cpu_rdy = ext_rdy AND (state==IDLE). This is combinational from the registered state.
- States: IDLE, RD, CAP, WR, RESTORE.
- IDLE: mem_* = cpu_*. A CTRL write with bit0=1 loads cnt=LEN (0 → 256; 9-bit counter) and latches src/dst working pointers. Next state is RD.
- RD: mem_addr=src, mem_wenb=1 → CAP.
- CAP: mem_addr=src, mem_wenb=1. Capture mem_d_in into data reg at edge → WR.
- WR: mem_addr=dst, mem_d_out=data reg, mem_wenb=0. At edge: src+=1, dst+=1 (13-bit wrap 1FFF→0000), cnt-=1. Next state is RD if cnt≠1, else RESTORE.
- RESTORE: mem_* = cpu_* (the CPU's frozen cycle is re-presented), cpu_rdy=0 → IDLE. done=1 in the first IDLE cycle (registered pulse).
- The CPU outputs are stable while cpu_rdy=0. RESTORE guarantees that mem_d_in holds the CPU's expected data in the cycle cpu_rdy returns high.
- Total CPU stall caused by DMA = 3*N+1 cycles, where N = 1..256.
- ext_rdy=0: the state machine and all counters hold. Bus outputs for the current state are held.
- During a DMA transfer, mem_d_out in non-WR states and the cpu_d_in value are don't-care.
- Start while not IDLE cannot occur (the CPU is stalled). CTRL writes with bit0=0 have no effect.
- rst mid-transfer: return to IDLE immediately at the edge, with all register values per reset. A partially copied destination is acceptable.

Test Plan:
1. SRC=0x0100, DST=0x0180, LEN=3, bytes 11/22/33, write CTRL=1 → cpu_rdy low exactly 10 cycles. mem[0180..0182]=11/22/33. done pulses once. The CPU's next opcode fetch returns the correct byte and execution continues correctly.
2. LEN=0 → 256 bytes copied. Stall is 769 cycles. busy is high throughout.
3. SRC=0x1FFF, DST=0x0010, LEN=2 → reads 0x1FFF then 0x0000, writes 0x0010/0x0011.
4. Hold ext_rdy=0 for 5 cycles during the second WR → no bus change while held. Stall extends by 5 cycles. Copy results are unchanged.
5. Assert rst in the CAP of byte 2 of an 8-byte copy → the next cycle shows IDLE, busy=0, cpu_rdy=1, no done pulse. Only byte 1 is written.
6. CPU writes 0xAA to CFG_BASE+2 → mem_wenb stays 1 that cycle and DST_LO=0xAA. A CPU write to CFG_BASE+8 passes through to memory.
